// File: rtl/mem_arb_pkg.sv
// Shared types and default memory geometry for the memory arbiter and the memory block it fronts.
package mem_arb_pkg;

  localparam int unsigned MEM_ADDR_WIDTH = 3;
  localparam int unsigned MEM_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first requester strictly after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N_REQ = 2,
  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  int unsigned      pos;
  logic [IDX_W-1:0] pos_idx;

  // Offset 1..N_REQ so ptr itself is checked last.
  always_comb begin
    grant   = '0;
    idx     = '0;
    found   = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      pos     = (32'(ptr) + i) % N_REQ;
      pos_idx = IDX_W'(pos);
      if (!found && req[pos_idx]) begin
        found          = 1'b1;
        idx            = pos_idx;
        grant[pos_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin sequencer sharing one single-port synchronous memory between N_REQ requesters;
// one command in flight at a time, read data routed back to the originator.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int unsigned N_REQ      = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0]            req_we,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [N_REQ-1:0]            req_ready,
  output logic [N_REQ-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]       resp_rdata,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  output logic                        mem_wr_en,
  output logic                        mem_rd_en,
  output logic [DATA_WIDTH-1:0]       mem_wr_data,
  input  logic [DATA_WIDTH-1:0]       mem_rd_data,
  output logic                        busy
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] idx_q;
  logic             we_q;

  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_found;
  logic             accept;

  logic [ADDR_WIDTH-1:0] addr_arr  [N_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [N_REQ];

  logic [N_REQ-1:0]      resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_rdata_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic                  mem_wr_en_d;
  logic                  mem_rd_en_d;
  logic [DATA_WIDTH-1:0] mem_wr_data_d;
  logic                  busy_d;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (grant_idx),
    .found (grant_found)
  );

  always_comb begin
    for (int i = 0; i < int'(N_REQ); i++) begin
      addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Ready is suppressed while reset is asserted so nothing is handshaken and then dropped.
  assign accept    = rst && (state_q == IDLE) && grant_found;
  assign req_ready = accept ? grant : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_found) state_d = ISSUE;
      ISSUE:   state_d = we_q ? IDLE : WAIT;
      WAIT:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs are computed one cycle ahead so they line up with the state they belong to.
  always_comb begin
    mem_addr_d    = mem_addr;
    mem_wr_data_d = mem_wr_data;
    mem_wr_en_d   = 1'b0;
    mem_rd_en_d   = 1'b0;
    resp_valid_d  = '0;
    resp_rdata_d  = resp_rdata;
    busy_d        = (state_d != IDLE);
    if (accept) begin
      mem_addr_d  = addr_arr[grant_idx];
      mem_wr_en_d = req_we[grant_idx];
      mem_rd_en_d = !req_we[grant_idx];
      if (req_we[grant_idx]) mem_wr_data_d = wdata_arr[grant_idx];
    end
    if (state_q == WAIT) begin
      resp_valid_d = N_REQ'(1) << idx_q;
      resp_rdata_d = mem_rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q       <= IDX_W'(N_REQ - 1);
      idx_q       <= '0;
      we_q        <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      mem_wr_en   <= 1'b0;
      mem_rd_en   <= 1'b0;
      resp_valid  <= '0;
      resp_rdata  <= '0;
      busy        <= 1'b0;
    end else begin
      if (accept) begin
        ptr_q <= grant_idx;
        idx_q <= grant_idx;
        we_q  <= req_we[grant_idx];
      end
      mem_addr    <= mem_addr_d;
      mem_wr_data <= mem_wr_data_d;
      mem_wr_en   <= mem_wr_en_d;
      mem_rd_en   <= mem_rd_en_d;
      resp_valid  <= resp_valid_d;
      resp_rdata  <= resp_rdata_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a 2-requester instance with a memory model and a 4-requester instance for wrap-around.
module tb_mem_arbiter;

  logic clk;
  logic rst;

  logic [1:0]  valid2, we2, ready2, rvalid2;
  logic [5:0]  addr2;
  logic [15:0] wdata2;
  logic [7:0]  rdata2, mwd2, mrd2;
  logic [2:0]  maddr2;
  logic        mwe2, mre2, busy2;

  logic [3:0]  valid4, we4, ready4, rvalid4;
  logic [11:0] addr4;
  logic [31:0] wdata4;
  logic [7:0]  rdata4, mwd4, mrd4;
  logic [2:0]  maddr4;
  logic        mwe4, mre4, busy4;

  logic [7:0] mem2 [8];

  int n_pass;
  int n_total;

  mem_arbiter #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .N_REQ(2)) u_dut (
    .clk(clk), .rst(rst), .req_valid(valid2), .req_we(we2), .req_addr(addr2), .req_wdata(wdata2),
    .req_ready(ready2), .resp_valid(rvalid2), .resp_rdata(rdata2), .mem_addr(maddr2),
    .mem_wr_en(mwe2), .mem_rd_en(mre2), .mem_wr_data(mwd2), .mem_rd_data(mrd2), .busy(busy2)
  );

  mem_arbiter #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .N_REQ(4)) u_dut4 (
    .clk(clk), .rst(rst), .req_valid(valid4), .req_we(we4), .req_addr(addr4), .req_wdata(wdata4),
    .req_ready(ready4), .resp_valid(rvalid4), .resp_rdata(rdata4), .mem_addr(maddr4),
    .mem_wr_en(mwe4), .mem_rd_en(mre4), .mem_wr_data(mwd4), .mem_rd_data(mrd4), .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous memory: read data appears the cycle after rd_en.
  always_ff @(posedge clk) begin
    if (mwe2) mem2[maddr2] <= mwd2;
    if (mre2) mrd2 <= mem2[maddr2];
  end
  assign mrd4 = 8'h00;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid2 = '0; we2 = '0; addr2 = '0; wdata2 = '0;
    valid4 = '0; we4 = '0; addr4 = '0; wdata4 = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      valid2 = 2'($urandom); we2 = 2'($urandom); addr2 = 6'($urandom); wdata2 = 16'($urandom);
      valid4 = 4'($urandom); we4 = 4'($urandom); addr4 = 12'($urandom); wdata4 = 32'($urandom);
      #1;
      n_total++;
      if ({ready2, rvalid2, rdata2, maddr2, mwe2, mre2, mwd2, busy2} !== '0)
        $display("FAIL reset_outs2 c%0d: got rdy=%b rv=%b rd=%h a=%h we=%b re=%b wd=%h busy=%b expected all 0",
                 c, ready2, rvalid2, rdata2, maddr2, mwe2, mre2, mwd2, busy2);
      else n_pass++;
      n_total++;
      if ({ready4, rvalid4, rdata4, maddr4, mwe4, mre4, mwd4, busy4} !== '0)
        $display("FAIL reset_outs4 c%0d: got rdy=%b busy=%b we=%b re=%b expected all 0", c, ready4, busy4, mwe4, mre4);
      else n_pass++;
    end
    tick();
    rst = 1'b1;
    idle_inputs();
  endtask

  task automatic test_write_read();
    valid2 = 2'b01; we2 = 2'b01; addr2 = 6'o05; wdata2 = 16'h00A5;
    #1;
    n_total++; if (ready2 !== 2'b01) $display("FAIL wr_ready: got %b expected 01", ready2); else n_pass++;
    tick();
    valid2 = 2'b00;
    n_total++;
    if ({mwe2, mre2, maddr2, mwd2, busy2} !== {1'b1, 1'b0, 3'd5, 8'hA5, 1'b1})
      $display("FAIL wr_issue: got we=%b re=%b a=%0d wd=%h busy=%b expected we=1 re=0 a=5 wd=a5 busy=1", mwe2, mre2, maddr2, mwd2, busy2);
    else n_pass++;
    tick();
    n_total++;
    if ({mwe2, busy2, maddr2, mwd2} !== {1'b0, 1'b0, 3'd5, 8'hA5})
      $display("FAIL wr_done: got we=%b busy=%b a=%0d wd=%h expected we=0 busy=0 a=5 wd=a5 held", mwe2, busy2, maddr2, mwd2);
    else n_pass++;
    valid2 = 2'b01; we2 = 2'b00; addr2 = 6'o05;
    #1;
    n_total++; if (ready2 !== 2'b01) $display("FAIL rd_ready: got %b expected 01", ready2); else n_pass++;
    tick();
    valid2 = 2'b00;
    n_total++;
    if ({mre2, mwe2, maddr2} !== {1'b1, 1'b0, 3'd5})
      $display("FAIL rd_issue: got re=%b we=%b a=%0d expected re=1 we=0 a=5", mre2, mwe2, maddr2);
    else n_pass++;
    tick();
    n_total++;
    if ({rvalid2, mre2, busy2} !== {2'b00, 1'b0, 1'b1})
      $display("FAIL rd_wait: got rv=%b re=%b busy=%b expected rv=00 re=0 busy=1", rvalid2, mre2, busy2);
    else n_pass++;
    tick();
    n_total++;
    if ({rvalid2, rdata2} !== {2'b01, 8'hA5})
      $display("FAIL rd_resp: got rv=%b rd=%h expected rv=01 rd=a5", rvalid2, rdata2);
    else n_pass++;
    tick();
    n_total++;
    if ({rvalid2, busy2, rdata2} !== {2'b00, 1'b0, 8'hA5})
      $display("FAIL rd_after: got rv=%b busy=%b rd=%h expected rv=00 busy=0 rd=a5 held", rvalid2, busy2, rdata2);
    else n_pass++;
  endtask

  task automatic test_contention();
    logic [1:0] exp_grant;
    logic [2:0] exp_addr;
    logic [7:0] exp_data;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    valid2 = 2'b11; we2 = 2'b11; addr2 = {3'd2, 3'd1}; wdata2 = {8'h22, 8'h11};
    for (int g = 0; g < 8; g++) begin
      exp_grant = (g % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr  = (g % 2 == 0) ? 3'd1 : 3'd2;
      exp_data  = (g % 2 == 0) ? 8'h11 : 8'h22;
      #1;
      n_total++;
      if (ready2 !== exp_grant) $display("FAIL cont_ready g%0d: got %b expected %b", g, ready2, exp_grant);
      else n_pass++;
      tick();
      n_total++;
      if ({mwe2, mre2, maddr2, mwd2} !== {1'b1, 1'b0, exp_addr, exp_data})
        $display("FAIL cont_issue g%0d: got we=%b re=%b a=%0d wd=%h expected we=1 re=0 a=%0d wd=%h",
                 g, mwe2, mre2, maddr2, mwd2, exp_addr, exp_data);
      else n_pass++;
      tick();
      n_total++;
      if ({mwe2, mre2} !== 2'b00) $display("FAIL cont_idle g%0d: got we=%b re=%b expected 0 0", g, mwe2, mre2);
      else n_pass++;
    end
    valid2 = 2'b00;
  endtask

  task automatic test_withdrawn();
    valid2 = 2'b01; we2 = 2'b10; addr2 = {3'd7, 3'd1}; wdata2 = {8'h77, 8'h00};
    #1;
    n_total++; if (ready2 !== 2'b01) $display("FAIL wd_ready0: got %b expected 01", ready2); else n_pass++;
    tick();
    valid2 = 2'b10;
    #1;
    n_total++;
    if ({ready2, mre2, mwe2} !== {2'b00, 1'b1, 1'b0})
      $display("FAIL wd_c1: got rdy=%b re=%b we=%b expected rdy=00 re=1 we=0", ready2, mre2, mwe2);
    else n_pass++;
    tick();
    n_total++;
    if ({ready2, mwe2} !== 3'b000) $display("FAIL wd_c2: got rdy=%b we=%b expected 00 0", ready2, mwe2); else n_pass++;
    tick();
    n_total++;
    if ({ready2, rvalid2, rdata2} !== {2'b00, 2'b01, 8'h11})
      $display("FAIL wd_c3: got rdy=%b rv=%b rd=%h expected rdy=00 rv=01 rd=11", ready2, rvalid2, rdata2);
    else n_pass++;
    valid2 = 2'b00;
    tick();
    n_total++;
    if ({ready2, busy2} !== 3'b000) $display("FAIL wd_c4: got rdy=%b busy=%b expected 00 0", ready2, busy2); else n_pass++;
    tick();
    n_total++;
    if ({mwe2, mre2, busy2, maddr2} !== {3'b000, 3'd1})
      $display("FAIL wd_c5: got we=%b re=%b busy=%b a=%0d expected 0 0 0 a=1", mwe2, mre2, busy2, maddr2);
    else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    valid2 = 2'b10; we2 = 2'b00; addr2 = {3'd2, 3'd0};
    #1;
    n_total++; if (ready2 !== 2'b10) $display("FAIL rmr_ready: got %b expected 10", ready2); else n_pass++;
    tick();
    valid2 = 2'b00;
    n_total++; if (mre2 !== 1'b1) $display("FAIL rmr_issue: got re=%b expected 1", mre2); else n_pass++;
    tick();
    rst = 1'b0;
    tick();
    n_total++;
    if ({rvalid2, rdata2, busy2, mre2, maddr2} !== '0)
      $display("FAIL rmr_after: got rv=%b rd=%h busy=%b re=%b a=%0d expected all 0", rvalid2, rdata2, busy2, mre2, maddr2);
    else n_pass++;
    rst = 1'b1;
    valid2 = 2'b11; we2 = 2'b11; addr2 = {3'd4, 3'd3}; wdata2 = {8'h44, 8'h33};
    #1;
    n_total++; if (ready2 !== 2'b01) $display("FAIL rmr_regrant: got %b expected 01", ready2); else n_pass++;
    tick();
    valid2 = 2'b00;
    n_total++;
    if ({rvalid2, mwe2, maddr2, mwd2} !== {2'b00, 1'b1, 3'd3, 8'h33})
      $display("FAIL rmr_wr: got rv=%b we=%b a=%0d wd=%h expected rv=00 we=1 a=3 wd=33", rvalid2, mwe2, maddr2, mwd2);
    else n_pass++;
    tick();
  endtask

  task automatic test_wrap();
    valid4 = 4'b1001; we4 = 4'b1111;
    addr4  = {3'd6, 3'd0, 3'd0, 3'd4};
    wdata4 = {8'h66, 8'h00, 8'h00, 8'h44};
    #1;
    n_total++; if (ready4 !== 4'b0001) $display("FAIL wrap_first: got %b expected 0001", ready4); else n_pass++;
    tick();
    valid4 = 4'b1000;
    n_total++;
    if ({mwe4, maddr4, mwd4} !== {1'b1, 3'd4, 8'h44})
      $display("FAIL wrap_wr0: got we=%b a=%0d wd=%h expected we=1 a=4 wd=44", mwe4, maddr4, mwd4);
    else n_pass++;
    tick();
    n_total++; if (ready4 !== 4'b1000) $display("FAIL wrap_second: got %b expected 1000", ready4); else n_pass++;
    tick();
    valid4 = 4'b0000;
    n_total++;
    if ({mwe4, mre4, maddr4, mwd4} !== {1'b1, 1'b0, 3'd6, 8'h66})
      $display("FAIL wrap_wr3: got we=%b re=%b a=%0d wd=%h expected we=1 re=0 a=6 wd=66", mwe4, mre4, maddr4, mwd4);
    else n_pass++;
    tick();
    n_total++;
    if ({ready4, busy4, mwe4} !== 6'b0) $display("FAIL wrap_idle: got rdy=%b busy=%b we=%b expected 0", ready4, busy4, mwe4);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b0;
    idle_inputs();
    test_reset();
    test_write_read();
    test_contention();
    test_withdrawn();
    test_reset_mid_read();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter and sequencer that shares a single-port synchronous memory (addr / wr_en / rd_en / wr_data / rd_data) between `N_REQ` requesters. It accepts one command at a time, drives the memory port so that write and read enables are never asserted together, and returns read data to the originating requester. It sits between the requesting masters and the memory DUT port.

## Interface
- `ADDR_WIDTH`, default 3: memory address width.
- `DATA_WIDTH`, default 8: memory data width.
- `N_REQ`, default 2: number of requesters, legal range 2..8.
- `clk`  in  1: single clock. All logic is rising-edge.
- `rst`  in  1: synchronous, active-low reset.
- `req_valid`  in  N_REQ: per-requester command valid.
- `req_we`  in  N_REQ: per-requester command type. 1 = write, 0 = read.
- `req_addr`  in  N_REQ*ADDR_WIDTH: packed per-requester address. Requester i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_wdata`  in  N_REQ*DATA_WIDTH: packed per-requester write data, same packing as `req_addr`.
- `req_ready`  out  N_REQ: one-hot accept strobe.
- `resp_valid`  out  N_REQ: one-hot, one-cycle read-response strobe.
- `resp_rdata`  out  DATA_WIDTH: read data, shared by all requesters.
- `mem_addr`  out  ADDR_WIDTH: memory address.
- `mem_wr_en`  out  1: memory write enable.
- `mem_rd_en`  out  1: memory read enable.
- `mem_wr_data`  out  DATA_WIDTH: memory write data.
- `mem_rd_data`  in  DATA_WIDTH: memory read data. Valid the cycle after `mem_rd_en`.
- `busy`  out  1: high whenever the state is not IDLE.

## Operation
- **States:** IDLE, ISSUE, WAIT, RESP. Encoded as an enum.
- **IDLE:**
  - If any `req_valid` is high, the round-robin winner w is selected.
  - `req_ready[w]` is driven combinationally high in the same cycle.
  - At the clock edge the arbiter latches w, `req_we[w]`, `req_addr[w]` and `req_wdata[w]`, sets ptr := w, and moves to ISSUE.
  - If no `req_valid` is high, it stays in IDLE.
- **Round-robin search:** starts at (ptr+1) mod N_REQ and moves upward, wrapping. The ptr reset value is N_REQ-1, so requester 0 has first priority after reset.
- **ISSUE:**
  - Drive `mem_addr` from the latched address.
  - Write: `mem_wr_en`=1 and `mem_wr_data` = latched data for exactly one cycle, then go to IDLE.
  - Read: `mem_rd_en`=1 for exactly one cycle, then go to WAIT.
- **WAIT:** register `mem_rd_data` into `resp_rdata`, then go to RESP.
- **RESP:** `resp_valid[w]`=1 for one cycle, then go to IDLE.
- **Invariants:**
  - `mem_wr_en & mem_rd_en` is never 1.
  - At most one bit of `req_ready` is set, and only for a requester whose `req_valid` is high.
  - At most one bit of `resp_valid` is set.
- **Requester obligation:** hold valid and payload stable until ready. Dropping valid before ready withdraws the request without penalty.
- **Held outputs:** `mem_addr` and `mem_wr_data` hold their last value outside ISSUE. `resp_rdata` holds its value until the next read completes.
- **Reset (including mid-operation):** the next state is IDLE and ptr = N_REQ-1. All outputs go to 0. Any in-flight command is dropped and produces no `resp_valid`.

## Timing
- Accept is at cycle 0, the cycle where `req_valid[w]` and `req_ready[w]` are both high.
- Write: `mem_wr_en` in cycle 1. The next accept is possible in cycle 2. Throughput is one write per 2 cycles.
- Read: `mem_rd_en` in cycle 1, `mem_rd_data` sampled at the end of cycle 2, `resp_valid` and `resp_rdata` in cycle 3. The next accept is possible in cycle 4.
- `req_ready` is combinational from state, ptr and `req_valid`. All other outputs are registered.

## Structure
- **Package `mem_arb_pkg`:** state enum typedef `arb_state_t`, and the default `ADDR_WIDTH`/`DATA_WIDTH` constants shared with the memory block.
- **Sub-module `rr_arbiter`:** combinational priority search. Parameter N_REQ; inputs req and ptr; outputs one-hot grant and index. Reused by later multi-master blocks.
- The top level holds the FSM, the command latch and ptr.

## Test plan
- **Reset values:** hold `rst`=0 for 3 cycles with random requests -> all outputs are 0, `busy`=0, no `req_ready`.
- **Single write then read:** requester 0 writes addr 5, data 0xA5, then reads addr 5 -> `mem_wr_en` in cycle 1 with `mem_addr`=5, `mem_wr_data`=0xA5; on the read, `resp_valid[0]` with `resp_rdata`=0xA5 exactly 3 cycles after accept.
- **Contention fairness:** requesters 0 and 1 both hold write requests continuously (addr 1 and 2) for 8 grants -> grants alternate 0,1,0,1,… and never both enables.
- **Withdrawn request:** requester 1 asserts valid while requester 0 is busy, then drops it before acceptance -> requester 1 gets no ready and no memory access.
- **Reset mid-read:** assert `rst`=0 in the WAIT cycle -> no `resp_valid`; after release the next grant goes to requester 0.
- **Wrap-around with N_REQ=4:** ptr=3 and requests from requesters 3 and 0 -> requester 0 is granted first, then requester 3.
